uart_wide_ram_bridge: RTL and testbench
=======================================

UART_WIDE_RAM_BRIDGE -- requirements
Module: uart_wide_ram_bridge

Interface
REQ-001 SHALL have parameter NUM_RAMS, default 2, number of RAM slaves (1..8).
REQ-002 SHALL have parameter RAM_WIDTH, default 16, RAM word width (multiple of 8, 8..32); BPW = RAM_WIDTH/8 bytes per word.
REQ-003 SHALL have parameter RAM_ADDR_BITS, default 13, RAM word-address width.
REQ-004 SHALL have parameter NUM_ADDR_BYTES, default 2, address bytes per frame (NUM_ADDR_BYTES*8 >= RAM_ADDR_BITS).
REQ-005 SHALL have parameter BASE_SLAVE_ID, default 1, slave_id of RAM 0; RAM k answers BASE_SLAVE_ID+k.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n_sync  in  1  synchronous active-low reset.
REQ-007 SHALL have ports: rx_data_out  in  8  received byte; rx_data_valid  in  1  one-cycle strobe per byte; rx_block_timeout  in  1  one-cycle strobe, rx line idle ends frame.
REQ-008 SHALL have ports: tx_bsy  in  1  transmitter busy; tx_trig  out  1  one-cycle send strobe; send_data  out  8  byte to send, valid while tx_trig high.
REQ-009 SHALL have ports: ram_address  out  RAM_ADDR_BITS  shared word address; ram_write_data  out  RAM_WIDTH  shared write word; ram_write_enable  out  NUM_RAMS  one-hot write strobe; ram_read_enable  out  NUM_RAMS  one-hot read strobe; ram_read_data  in  NUM_RAMS*RAM_WIDTH  RAM k at bits [k*RAM_WIDTH +: RAM_WIDTH], valid one cycle after ram_read_enable.

Function
REQ-010 SHALL parse frames: byte0 = {rw, slave_id[6:0]} (rw=1 read), then NUM_ADDR_BYTES address bytes MSB first; only address[RAM_ADDR_BITS-1:0] used, upper bits ignored.
REQ-011 SHALL use states IDLE, ADDR, WDATA, RLEN, RREQ, RCAP, RSEND, RWAIT_HI, RWAIT_LO.
REQ-012 IDLE: rx_data_valid -> latch byte0, clear byte counter, go ADDR; rx_block_timeout ignored.
REQ-013 ADDR: after last address byte -> WDATA if rw=0, RLEN if rw=1.
REQ-014 WDATA: bytes assemble little-endian (first byte -> bits [7:0]); on BPW-th byte, ram_write_data and one-hot ram_write_enable asserted the next cycle for exactly one cycle, then address increments.
REQ-015 RLEN: next byte L gives L+1 words to read; go RSEND with echo byte {1'b1, slave_id} queued first.
REQ-016 Read sequence: echo byte sent; per word: RREQ asserts ram_read_enable one cycle, RCAP captures selected ram_read_data next cycle into shift register, then BPW bytes sent LSB first; address increments after each word.
REQ-017 tx handshake: tx_trig pulses only when tx_bsy=0; then RWAIT_HI waits tx_bsy=1 (asserted by transmitter cycle after tx_trig), RWAIT_LO waits tx_bsy=0 before next byte.
REQ-018 After last byte of word L+1 transmitted -> IDLE.
REQ-019 Address increment SHALL wrap 2^RAM_ADDR_BITS-1 -> 0.
REQ-020 slave_id outside [BASE_SLAVE_ID, BASE_SLAVE_ID+NUM_RAMS-1]: no ram enables ever asserted; writes consumed and discarded; reads still echo and send (L+1)*BPW bytes of 0x00.
REQ-021 rx_block_timeout in ADDR, WDATA or RLEN -> IDLE next cycle; partial word discarded, no write.
REQ-022 During read states rx_data_valid and rx_block_timeout SHALL be ignored; read always completes.
REQ-023 rx_data_valid and rx_block_timeout in same cycle: byte processed first, then IDLE (completed word still written).
REQ-024 At most one bit of ram_write_enable | ram_read_enable high in any cycle.

Reset
REQ-025 rst_n_sync=0 at clk edge: state IDLE, counters/address/shift register 0, tx_trig=0, send_data=0, ram_write_enable=0, ram_read_enable=0, ram_write_data=0, ram_address=0.
REQ-026 Reset mid-frame or mid-read SHALL abort with no further strobes; first byte after reset is byte0.

Verification (NUM_RAMS=2, RAM_WIDTH=16, RAM_ADDR_BITS=4, NUM_ADDR_BYTES=2, BASE_SLAVE_ID=1)
REQ-027 Write: 01 00 03 CD AB 34 12, timeout -> ram_write_enable=01 addr 3 data ABCD, then addr 4 data 1234; no other strobes.
REQ-028 Read wrap: 82 00 0F 01, RAM1[15]=BEEF, RAM1[0]=1234 -> send 82 EF BE 34 12; ram_read_enable=10 at addr 15 then 0.
REQ-029 Partial word: 01 00 05 EE, timeout -> no ram_write_enable; following frame 01 00 05 11 22 writes 2211 at addr 5.
REQ-030 Unmatched id: 85 00 00 00 -> send 85 00 00; ram_read_enable never high.
REQ-031 Reset during RWAIT_LO of 2nd read byte -> tx_trig stays 0, state IDLE, next frame 01 01 02 AA BB writes BBAA at addr 2.
REQ-032 tx_bsy held high 50 cycles per byte -> no tx_trig while tx_bsy=1; byte order unchanged.

Source files
------------

// File: rtl/uart_wide_ram_bridge.sv
// UART frame to multi-RAM bridge: byte-stream writes of little-endian words, and
// read bursts that are echoed and returned LSB first through a handshaked transmitter.
//
// state    | meaning
// IDLE     | waiting for byte0 {rw, slave_id}
// ADDR     | shifting in address bytes, MSB first
// WDATA    | assembling write words, one strobe per completed word
// RLEN     | waiting for word count byte L (L+1 words)
// RREQ     | read strobe to selected RAM
// RCAP     | capture returned word into shift register
// RSEND    | launch next byte once transmitter is free
// RWAIT_HI | wait for transmitter to go busy
// RWAIT_LO | wait for transmitter to finish
module uart_wide_ram_bridge #(
   parameter int NUM_RAMS       = 2,
   parameter int RAM_WIDTH      = 16,
   parameter int RAM_ADDR_BITS  = 13,
   parameter int NUM_ADDR_BYTES = 2,
   parameter int BASE_SLAVE_ID  = 1
) (
   input  logic                          clk,
   input  logic                          rst_n_sync,
   input  logic [7:0]                    rx_data_out,
   input  logic                          rx_data_valid,
   input  logic                          rx_block_timeout,
   input  logic                          tx_bsy,
   output logic                          tx_trig,
   output logic [7:0]                    send_data,
   output logic [RAM_ADDR_BITS-1:0]      ram_address,
   output logic [RAM_WIDTH-1:0]          ram_write_data,
   output logic [NUM_RAMS-1:0]           ram_write_enable,
   output logic [NUM_RAMS-1:0]           ram_read_enable,
   input  logic [NUM_RAMS*RAM_WIDTH-1:0] ram_read_data
);

   localparam int BPW = RAM_WIDTH / 8;

   typedef enum logic [3:0] {
      IDLE, ADDR, WDATA, RLEN, RREQ, RCAP, RSEND, RWAIT_HI, RWAIT_LO
   } state_t;

   state_t                   state_q, state_d;
   logic                     rw_q, rw_d;
   logic [6:0]               id_q, id_d;
   logic                     hit_q, hit_d;
   logic [2:0]               sel_q, sel_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [7:0]               len_q, len_d;
   logic                     echo_q, echo_d;
   logic                     inc_q, inc_d;
   logic [RAM_WIDTH-1:0]     wbuf_q, wbuf_d;
   logic [RAM_WIDTH-1:0]     shift_q, shift_d;
   logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [RAM_WIDTH-1:0]     wdata_q, wdata_d;
   logic [NUM_RAMS-1:0]      we_q, we_d;
   logic                     tx_trig_q, tx_trig_d;
   logic [7:0]               send_q, send_d;

   logic                     id_hit;
   logic [2:0]               id_sel;
   logic [NUM_RAMS-1:0]      onehot;
   logic [RAM_WIDTH-1:0]     rd_sel;
   logic [RAM_WIDTH-1:0]     wbuf_tmp;

   assign id_hit = (int'(rx_data_out[6:0]) >= BASE_SLAVE_ID) &&
                   (int'(rx_data_out[6:0]) <  BASE_SLAVE_ID + NUM_RAMS);
   assign id_sel = 3'(int'(rx_data_out[6:0]) - BASE_SLAVE_ID);
   assign onehot = NUM_RAMS'(1) << sel_q;

   always_comb begin
      rd_sel = '0;
      for (int k = 0; k < NUM_RAMS; k++) begin
         if (sel_q == 3'(k)) rd_sel = ram_read_data[k*RAM_WIDTH +: RAM_WIDTH];
      end
   end

   always_comb begin
      wbuf_tmp = wbuf_q;
      for (int b = 0; b < BPW; b++) begin
         if (cnt_q == 8'(b)) wbuf_tmp[b*8 +: 8] = rx_data_out;
      end
   end

   always_comb begin
      state_d   = state_q;
      rw_d      = rw_q;
      id_d      = id_q;
      hit_d     = hit_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      echo_d    = echo_q;
      inc_d     = 1'b0;
      wbuf_d    = wbuf_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = '0;
      tx_trig_d = 1'b0;
      send_d    = send_q;
      // address steps in the same cycle the write strobe is visible
      if (inc_q) addr_d = addr_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (rx_data_valid) begin
               rw_d    = rx_data_out[7];
               id_d    = rx_data_out[6:0];
               hit_d   = id_hit;
               sel_d   = id_sel;
               cnt_d   = '0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (rx_data_valid) begin
               addr_d = RAM_ADDR_BITS'({addr_q, rx_data_out});
               if (cnt_q == 8'(NUM_ADDR_BYTES - 1)) begin
                  cnt_d   = '0;
                  state_d = rw_q ? RLEN : WDATA;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            if (rx_block_timeout) state_d = IDLE;
         end
         WDATA: begin
            if (rx_data_valid) begin
               wbuf_d = wbuf_tmp;
               if (cnt_q == 8'(BPW - 1)) begin
                  wdata_d = wbuf_tmp;
                  we_d    = hit_q ? onehot : '0;
                  inc_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            if (rx_block_timeout) state_d = IDLE;
         end
         RLEN: begin
            if (rx_data_valid) begin
               len_d        = rx_data_out;
               echo_d       = 1'b1;
               shift_d      = '0;
               shift_d[7:0] = {1'b1, id_q};
               state_d      = RSEND;
            end else if (rx_block_timeout) begin
               state_d = IDLE;
            end
         end
         RREQ: state_d = RCAP;
         RCAP: begin
            shift_d = hit_q ? rd_sel : '0;
            addr_d  = addr_q + 1'b1;
            cnt_d   = '0;
            state_d = RSEND;
         end
         RSEND: begin
            if (!tx_bsy) begin
               tx_trig_d = 1'b1;
               send_d    = shift_q[7:0];
               state_d   = RWAIT_HI;
            end
         end
         RWAIT_HI: if (tx_bsy) state_d = RWAIT_LO;
         RWAIT_LO: begin
            if (!tx_bsy) begin
               if (echo_q) begin
                  echo_d  = 1'b0;
                  state_d = RREQ;
               end else begin
                  shift_d = shift_q >> 8;
                  if (cnt_q == 8'(BPW - 1)) begin
                     cnt_d = '0;
                     if (len_q == 8'd0) begin
                        state_d = IDLE;
                     end else begin
                        len_d   = len_q - 8'd1;
                        state_d = RREQ;
                     end
                  end else begin
                     cnt_d   = cnt_q + 8'd1;
                     state_d = RSEND;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n_sync) begin
         state_q   <= IDLE;
         rw_q      <= 1'b0;
         id_q      <= '0;
         hit_q     <= 1'b0;
         sel_q     <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         echo_q    <= 1'b0;
         inc_q     <= 1'b0;
         wbuf_q    <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= '0;
         tx_trig_q <= 1'b0;
         send_q    <= '0;
      end else begin
         state_q   <= state_d;
         rw_q      <= rw_d;
         id_q      <= id_d;
         hit_q     <= hit_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         echo_q    <= echo_d;
         inc_q     <= inc_d;
         wbuf_q    <= wbuf_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         tx_trig_q <= tx_trig_d;
         send_q    <= send_d;
      end
   end

   // read strobe is combinational so RAM data lands while in RCAP
   assign ram_read_enable  = (state_q == RREQ && hit_q) ? onehot : '0;
   assign ram_write_enable = we_q;
   assign ram_write_data   = wdata_q;
   assign ram_address      = addr_q;
   assign tx_trig          = tx_trig_q;
   assign send_data        = send_q;

endmodule

// File: tb/tb_uart_wide_ram_bridge.sv
// Scoreboard bench for uart_wide_ram_bridge: RAM and transmitter models, expected
// strobes and bytes queued at stimulus time and compared as the DUT produces them.
module tb_uart_wide_ram_bridge;

   logic        clk = 1'b0;
   logic        rst_n_sync = 1'b0;
   logic [7:0]  rx_data_out = '0;
   logic        rx_data_valid = 1'b0;
   logic        rx_block_timeout = 1'b0;
   logic        tx_bsy;
   logic        tx_trig;
   logic [7:0]  send_data;
   logic [3:0]  ram_address;
   logic [15:0] ram_write_data;
   logic [1:0]  ram_write_enable;
   logic [1:0]  ram_read_enable;
   logic [31:0] ram_read_data = '0;

   uart_wide_ram_bridge #(
      .NUM_RAMS(2), .RAM_WIDTH(16), .RAM_ADDR_BITS(4),
      .NUM_ADDR_BYTES(2), .BASE_SLAVE_ID(1)
   ) dut (
      .clk(clk), .rst_n_sync(rst_n_sync),
      .rx_data_out(rx_data_out), .rx_data_valid(rx_data_valid),
      .rx_block_timeout(rx_block_timeout),
      .tx_bsy(tx_bsy), .tx_trig(tx_trig), .send_data(send_data),
      .ram_address(ram_address), .ram_write_data(ram_write_data),
      .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
      .ram_read_data(ram_read_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // RAM model, with a poke port for preloading
   logic [15:0] mem [0:1][0:15];
   logic        poke_en = 1'b0;
   int          poke_k = 0;
   logic [3:0]  poke_a = '0;
   logic [15:0] poke_d = '0;

   always @(posedge clk) begin
      if (poke_en) mem[poke_k][poke_a] <= poke_d;
      for (int k = 0; k < 2; k++) begin
         if (ram_write_enable[k]) mem[k][ram_address] <= ram_write_data;
         if (ram_read_enable[k]) ram_read_data[k*16 +: 16] <= mem[k][ram_address];
      end
   end

   // transmitter model: busy from the cycle after tx_trig for bsy_len cycles
   int bsy_len = 5;
   int bsy_cnt = 0;
   always @(posedge clk) begin
      if (tx_trig) bsy_cnt <= bsy_len;
      else if (bsy_cnt != 0) bsy_cnt <= bsy_cnt - 1;
   end
   assign tx_bsy = (bsy_cnt != 0);

   logic [7:0]  exp_tx[$];
   logic [31:0] exp_wr[$];
   logic [31:0] exp_rd[$];
   int tx_seen = 0, tx_pushed = 0;
   int wr_seen = 0, wr_pushed = 0;
   int rd_seen = 0, rd_pushed = 0;

   always @(negedge clk) begin
      if (rst_n_sync) begin
         if (tx_trig) begin
            tx_seen++;
            chk("trig_while_bsy", {31'b0, tx_bsy}, 32'd0);
            if (exp_tx.size() > 0) chk("tx_byte", {24'b0, send_data}, {24'b0, exp_tx.pop_front()});
         end
         if (ram_write_enable != 2'b00) begin
            wr_seen++;
            if (exp_wr.size() > 0)
               chk("wr", {10'b0, ram_write_enable, ram_address, ram_write_data}, exp_wr.pop_front());
         end
         if (ram_read_enable != 2'b00) begin
            rd_seen++;
            if (exp_rd.size() > 0)
               chk("rd", {26'b0, ram_read_enable, ram_address}, exp_rd.pop_front());
         end
         if ((ram_write_enable | ram_read_enable) != 2'b00)
            chk("onehot", 32'($countones({ram_write_enable, ram_read_enable})), 32'd1);
      end
   end

   task automatic push_tx(input logic [7:0] b);
      exp_tx.push_back(b);
      tx_pushed++;
   endtask

   task automatic push_wr(input logic [1:0] we, input logic [3:0] a, input logic [15:0] d);
      exp_wr.push_back({10'b0, we, a, d});
      wr_pushed++;
   endtask

   task automatic push_rd(input logic [1:0] re, input logic [3:0] a);
      exp_rd.push_back({26'b0, re, a});
      rd_pushed++;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic with_to);
      @(negedge clk);
      rx_data_out      = b;
      rx_data_valid    = 1'b1;
      rx_block_timeout = with_to;
      @(negedge clk);
      rx_data_valid    = 1'b0;
      rx_block_timeout = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] fr[$]);
      foreach (fr[i]) send_byte(fr[i], 1'b0);
   endtask

   task automatic pulse_timeout();
      @(negedge clk);
      rx_block_timeout = 1'b1;
      @(negedge clk);
      rx_block_timeout = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic poke(input int k, input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      poke_en = 1'b1; poke_k = k; poke_a = a; poke_d = d;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 3000; i++) begin
         if (exp_tx.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0 && !tx_bsy) break;
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk({tag, "_tx_count"}, 32'(tx_seen), 32'(tx_pushed));
      chk({tag, "_wr_count"}, 32'(wr_seen), 32'(wr_pushed));
      chk({tag, "_rd_count"}, 32'(rd_seen), 32'(rd_pushed));
      exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
      tx_pushed = tx_seen; wr_pushed = wr_seen; rd_pushed = rd_seen;
   endtask

   task automatic reset_and_check(input string tag);
      @(negedge clk);
      rst_n_sync = 1'b0;
      repeat (2) @(negedge clk);
      chk({tag, "_tx_trig"}, {31'b0, tx_trig}, 32'd0);
      chk({tag, "_send_data"}, {24'b0, send_data}, 32'd0);
      chk({tag, "_we"}, {30'b0, ram_write_enable}, 32'd0);
      chk({tag, "_re"}, {30'b0, ram_read_enable}, 32'd0);
      chk({tag, "_wdata"}, {16'b0, ram_write_data}, 32'd0);
      chk({tag, "_addr"}, {28'b0, ram_address}, 32'd0);
      rst_n_sync = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int i;
      repeat (3) @(negedge clk);
      reset_and_check("rst0");

      // two-word write, little-endian assembly, address increment
      push_wr(2'b01, 4'd3, 16'hABCD);
      push_wr(2'b01, 4'd4, 16'h1234);
      send_frame('{8'h01, 8'h00, 8'h03, 8'hCD, 8'hAB, 8'h34, 8'h12});
      pulse_timeout();
      drain("write2");

      // read two words from RAM1 across the address wrap
      poke(1, 4'd15, 16'hBEEF);
      poke(1, 4'd0, 16'h1234);
      push_rd(2'b10, 4'd15);
      push_rd(2'b10, 4'd0);
      push_tx(8'h82); push_tx(8'hEF); push_tx(8'hBE); push_tx(8'h34); push_tx(8'h12);
      send_frame('{8'h82, 8'h00, 8'h0F, 8'h01});
      drain("read_wrap");

      // partial word discarded, then full word at the same address
      send_frame('{8'h01, 8'h00, 8'h05, 8'hEE});
      pulse_timeout();
      drain("partial");
      push_wr(2'b01, 4'd5, 16'h2211);
      send_frame('{8'h01, 8'h00, 8'h05, 8'h11, 8'h22});
      pulse_timeout();
      drain("after_partial");

      // unmatched slave id reads zeros, no strobes
      push_tx(8'h85); push_tx(8'h00); push_tx(8'h00);
      send_frame('{8'h85, 8'h00, 8'h00, 8'h00});
      drain("unmatched");

      // final data byte coincides with timeout: word still written
      push_wr(2'b10, 4'd7, 16'h2211);
      send_frame('{8'h02, 8'h00, 8'h07, 8'h11});
      send_byte(8'h22, 1'b1);
      drain("same_cycle");

      // write wrap 15 -> 0 on RAM1
      push_wr(2'b10, 4'd15, 16'h0001);
      push_wr(2'b10, 4'd0, 16'h0002);
      send_frame('{8'h02, 8'h00, 8'h0F, 8'h01, 8'h00, 8'h02, 8'h00});
      pulse_timeout();
      drain("write_wrap");

      // read back words written through the bridge
      push_rd(2'b01, 4'd3);
      push_rd(2'b01, 4'd4);
      push_tx(8'h81); push_tx(8'hCD); push_tx(8'hAB); push_tx(8'h34); push_tx(8'h12);
      send_frame('{8'h81, 8'h00, 8'h03, 8'h01});
      drain("readback");

      // slow transmitter
      bsy_len = 50;
      push_rd(2'b01, 4'd5);
      push_tx(8'h81); push_tx(8'h11); push_tx(8'h22);
      send_frame('{8'h81, 8'h00, 8'h05, 8'h00});
      drain("slow_tx");
      bsy_len = 5;

      // reset while waiting for the 2nd read byte to finish
      push_rd(2'b01, 4'd3);
      push_tx(8'h81); push_tx(8'hCD);
      base = tx_pushed - 2;
      send_frame('{8'h81, 8'h00, 8'h03, 8'h00});
      for (i = 0; i < 500; i++) begin
         if (tx_seen >= base + 2) break;
         @(negedge clk);
      end
      chk("mid_read_bytes", 32'(tx_seen), 32'(base + 2));
      for (i = 0; i < 100; i++) begin
         if (tx_bsy) break;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      reset_and_check("rst_mid");
      base = tx_seen;
      repeat (60) @(negedge clk);
      chk("rst_no_trig", 32'(tx_seen), 32'(base));
      drain("rst_mid");
      push_wr(2'b01, 4'd2, 16'hBBAA);
      send_frame('{8'h01, 8'h01, 8'h02, 8'hAA, 8'hBB});
      pulse_timeout();
      drain("post_rst_write");
      push_rd(2'b01, 4'd2);
      push_tx(8'h81); push_tx(8'hAA); push_tx(8'hBB);
      send_frame('{8'h81, 8'h00, 8'h02, 8'h00});
      drain("post_rst_read");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
